// File: rtl/jtag_dbg_cmd_sequencer_if.sv
// Debug register bus between the JTAG command sequencer (master) and the SoC
// debug fabric (slave): single outstanding req/gnt request, rvalid response.
interface jtag_dbg_cmd_sequencer_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              gnt;
   logic              rvalid;
   logic [31:0]       rdata;
   logic              err;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/jtag_dbg_cmd_sequencer.sv
// Decodes debug DR words from the TAP into debug-bus reads/writes and returns
// read data/status for the next Capture-DR. Optional: JTAG_DBG_AUTOINC_EN.
module jtag_dbg_cmd_sequencer #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] dr_out_i,
   input  logic        dr_valid_i,
   input  logic        dr_done_i,
   output logic [31:0] dr_in_o,
   output logic        busy_o,
   jtag_dbg_cmd_sequencer_if.master dbg
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_NOP      = 3'b000;
   localparam logic [2:0] OP_SET_ADDR = 3'b001;
   localparam logic [2:0] OP_READ     = 3'b010;
   localparam logic [2:0] OP_WDATA_HI = 3'b011;
   localparam logic [2:0] OP_WRITE    = 3'b100;
   localparam logic [2:0] OP_CLR      = 3'b101;
   localparam logic [2:0] OP_STATUS   = 3'b110;
   localparam logic [2:0] OP_RSVD     = 3'b111;

   localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic              lvl_q, stb_q;
   logic [31:0]       cmd_q;
   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_hi_q, wdata_hi_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d, tout_q, tout_d, ovr_q, ovr_d;
   logic [15:0]       addr16;
   logic [31:0]       status;
   logic              lvl;

   generate
      if (ADDR_W >= 16) begin : g_addr_trunc
         assign addr16 = addr_q[15:0];
      end else begin : g_addr_ext
         assign addr16 = {{(16 - ADDR_W){1'b0}}, addr_q};
      end
   endgenerate

   assign lvl    = dr_done_i & dr_valid_i;
   assign busy_o = (state_q != S_IDLE);
   assign status = {busy_o, err_q, tout_q, ovr_q, 12'b0, addr16};

   assign dbg.req   = (state_q == S_REQ);
   assign dbg.we    = we_q;
   assign dbg.addr  = addr_q;
   assign dbg.wdata = wdata_q;
   assign dr_in_o   = rdata_q;

   // One strobe per Update-DR: the word is latched on the rising edge of the
   // qualified level and decoded the following cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lvl_q <= 1'b0;
         stb_q <= 1'b0;
         cmd_q <= '0;
      end else begin
         lvl_q <= lvl;
         stb_q <= lvl & ~lvl_q;
         if (lvl & ~lvl_q) cmd_q <= dr_out_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_hi_d = wdata_hi_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      tout_d     = tout_q;
      ovr_d      = ovr_q;

      if (stb_q) begin
         if (state_q != S_IDLE) begin
            ovr_d = 1'b1;
         end else begin
            case (cmd_q[31:29])
               OP_NOP:      ;
               OP_SET_ADDR: addr_d = {cmd_q[ADDR_W-1:2], 2'b00};
               OP_READ: begin
                  we_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = S_REQ;
               end
               OP_WDATA_HI: wdata_hi_d = cmd_q[15:0];
               OP_WRITE: begin
                  we_d    = 1'b1;
                  wdata_d = {wdata_hi_q, cmd_q[15:0]};
                  cnt_d   = '0;
                  state_d = S_REQ;
               end
               OP_CLR: begin
                  err_d  = 1'b0;
                  tout_d = 1'b0;
                  ovr_d  = 1'b0;
               end
               OP_STATUS:   rdata_d = status;
               OP_RSVD:     err_d = 1'b1;
               default:     ;
            endcase
         end
      end

      // Bus progress wins over timeout when both land on the final cycle.
      case (state_q)
         S_REQ, S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == S_REQ && dbg.gnt) begin
               state_d = S_WAIT;
            end else if (state_q == S_WAIT && dbg.rvalid) begin
               state_d = S_DONE;
               if (dbg.err) begin
                  err_d = 1'b1;
               end else begin
                  if (!we_q) rdata_d = dbg.rdata;
`ifdef JTAG_DBG_AUTOINC_EN
                  addr_d = addr_q + ADDR_W'(4);
`endif
               end
            end else if (cnt_q >= TOUT_LAST) begin
               state_d = S_IDLE;
               tout_d  = 1'b1;
               rdata_d = 32'hDEAD_0000;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_hi_q <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         tout_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_hi_q <= wdata_hi_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         tout_q     <= tout_d;
         ovr_q      <= ovr_d;
      end
   end
endmodule
